// File: rtl/aes_dec_cntx.sv
// AES-128 inverse-cipher round controller: optional forward key expansion, then 11 inverse rounds.
// Outputs decode only from registered state and counters; the done pulse comes 22 cycles after accept (12 with key_same).
module aes_dec_cntx (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_same,
  input  logic       abort,
  output logic       accept,
  output logic       busy,
  output logic [3:0] rnd_no,
  output logic       enb_isb,
  output logic       enb_isr,
  output logic       enb_imc,
  output logic       enb_ar,
  output logic       enb_ks,
  output logic       ks_dir,
  output logic       done,
  output logic [9:0] completed_round
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] kcnt, kcnt_nxt;
  logic [3:0] rnd, rnd_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kcnt  <= 4'd0;
      rnd   <= 4'd0;
    end else begin
      state <= state_nxt;
      kcnt  <= kcnt_nxt;
      rnd   <= rnd_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    kcnt_nxt        = kcnt;
    rnd_nxt         = rnd;
    accept          = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    rnd_no          = 4'd0;
    enb_isb         = 1'b0;
    enb_isr         = 1'b0;
    enb_imc         = 1'b0;
    enb_ar          = 1'b0;
    enb_ks          = 1'b0;
    ks_dir          = 1'b0;
    completed_round = 10'd0;

    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      kcnt_nxt  = 4'd0;
      rnd_nxt   = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          kcnt_nxt = 4'd0;
          rnd_nxt  = 4'd0;
          if (start && !abort) begin
            if (key_same) begin
              state_nxt = ROUND;
              rnd_nxt   = 4'd10;
            end else begin
              state_nxt = KEXP;
              kcnt_nxt  = 4'd1;
            end
          end
        end
        KEXP: begin
          if (kcnt == 4'd10) begin
            state_nxt = ROUND;
            kcnt_nxt  = 4'd0;
            rnd_nxt   = 4'd10;
          end else begin
            kcnt_nxt = kcnt + 4'd1;
          end
        end
        ROUND: begin
          if (rnd == 4'd0) state_nxt = DONE;
          else             rnd_nxt   = rnd - 4'd1;
        end
        default: begin
          state_nxt = IDLE;
          kcnt_nxt  = 4'd0;
          rnd_nxt   = 4'd0;
        end
      endcase
    end

    accept = (state == IDLE);
    busy   = (state == KEXP) || (state == ROUND);
    done   = (state == DONE);

    if (state == KEXP) enb_ks = 1'b1;

    // Round 10 is the lone AddRoundKey; round 0 skips InvMixColumns and the key step.
    if (state == ROUND) begin
      rnd_no  = rnd;
      enb_ar  = 1'b1;
      enb_isb = (rnd != 4'd10);
      enb_isr = (rnd != 4'd10);
      enb_imc = (rnd != 4'd10) && (rnd != 4'd0);
      enb_ks  = (rnd != 4'd0);
      ks_dir  = (rnd != 4'd0);
      if (rnd != 4'd0 && rnd <= 4'd10) completed_round = 10'd1 << (4'd10 - rnd);
    end
  end

endmodule

// File: tb/tb_aes_dec_cntx.sv
// Directed bench for aes_dec_cntx: reset, both start flavours, back-to-back, abort and mid-run reset.
module tb_aes_dec_cntx;

  logic       clk = 1'b0;
  logic       rst, start, key_same, abort;
  logic       accept, busy, done, enb_isb, enb_isr, enb_imc, enb_ar, enb_ks, ks_dir;
  logic [3:0] rnd_no;
  logic [9:0] completed_round;
  logic [22:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int S_IDLE = 0, S_KEXP = 1, S_ROUND = 2, S_DONE = 3;

  always #5 clk = ~clk;

  aes_dec_cntx dut (
    .clk(clk), .rst(rst), .start(start), .key_same(key_same), .abort(abort),
    .accept(accept), .busy(busy), .rnd_no(rnd_no),
    .enb_isb(enb_isb), .enb_isr(enb_isr), .enb_imc(enb_imc), .enb_ar(enb_ar),
    .enb_ks(enb_ks), .ks_dir(ks_dir), .done(done), .completed_round(completed_round)
  );

  assign obs = {accept, busy, done, rnd_no, enb_isb, enb_isr, enb_imc, enb_ar,
                enb_ks, ks_dir, completed_round};

  // Expected {accept,busy,done,rnd_no,isb,isr,imc,ar,ks,ks_dir,completed_round}.
  function automatic logic [22:0] exp_vec(input int st, input int r);
    logic       acc, bsy, dn, isb, isr, imc, ar, ks, kd;
    logic [3:0] rn;
    logic [9:0] cr;
    acc = (st == S_IDLE);
    bsy = (st == S_KEXP) || (st == S_ROUND);
    dn  = (st == S_DONE);
    rn = 4'd0; isb = 0; isr = 0; imc = 0; ar = 0; ks = 0; kd = 0; cr = 10'd0;
    if (st == S_KEXP) ks = 1;
    if (st == S_ROUND) begin
      rn  = r[3:0];
      ar  = 1;
      isb = (r <= 9);
      isr = (r <= 9);
      imc = (r >= 1) && (r <= 9);
      ks  = (r >= 1);
      kd  = (r >= 1);
      if (r >= 1) cr = 10'd1 << (10 - r);
    end
    return {acc, bsy, dn, rn, isb, isr, imc, ar, ks, kd, cr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [22:0] e;
    rst = 1; start = 1; key_same = 0; abort = 1;
    tick();
    tick();
    e = exp_vec(S_IDLE, 0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_state got %h want %h", obs, e); end
    abort = 0;
    rst = 0;
    tick();
    e = exp_vec(S_KEXP, 0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL start_after_rst got %h want %h", obs, e); end
    start = 0; abort = 1;
    tick();
    abort = 1;
    tick();
    abort = 0;
    e = exp_vec(S_IDLE, 0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL abort_in_idle got %h want %h", obs, e); end
  endtask

  task automatic test_full_kexp();
    logic [22:0] e;
    int n_imc = 0, n_ar = 0, n_ksi = 0;
    start = 1; key_same = 0;
    tick();
    start = 0;
    for (int c = 1; c <= 22; c++) begin
      if (c <= 10)      e = exp_vec(S_KEXP, 0);
      else if (c <= 21) e = exp_vec(S_ROUND, 21 - c);
      else              e = exp_vec(S_DONE, 0);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL kexp_run c=%0d got %h want %h", c, obs, e); end
      if (enb_imc) n_imc++;
      if (enb_ar) n_ar++;
      if (enb_ks && ks_dir) n_ksi++;
      tick();
    end
    e = exp_vec(S_IDLE, 0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL kexp_return_idle got %h want %h", obs, e); end
    n_checks++;
    if (n_imc !== 9) begin n_fail++; $display("FAIL imc_count got %0d want 9", n_imc); end
    n_checks++;
    if (n_ar !== 11) begin n_fail++; $display("FAIL ar_count got %0d want 11", n_ar); end
    n_checks++;
    if (n_ksi !== 10) begin n_fail++; $display("FAIL ks_inv_count got %0d want 10", n_ksi); end
  endtask

  task automatic test_key_same();
    logic [22:0] e;
    start = 1; key_same = 1;
    tick();
    start = 0; key_same = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 11) e = exp_vec(S_ROUND, 11 - c);
      else         e = exp_vec(S_DONE, 0);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL key_same_run c=%0d got %h want %h", c, obs, e); end
      tick();
    end
    e = exp_vec(S_IDLE, 0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL key_same_idle got %h want %h", obs, e); end
  endtask

  task automatic test_back_to_back();
    logic [22:0] e;
    int p;
    start = 1; key_same = 1;
    tick();
    for (int c = 1; c <= 26; c++) begin
      p = ((c - 1) % 13) + 1;
      if (p <= 11)      e = exp_vec(S_ROUND, 11 - p);
      else if (p == 12) e = exp_vec(S_DONE, 0);
      else              e = exp_vec(S_IDLE, 0);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL b2b c=%0d got %h want %h", c, obs, e); end
      if (c < 26) tick();
    end
    start = 0;
    tick();
    e = exp_vec(S_IDLE, 0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL b2b_stop got %h want %h", obs, e); end
  endtask

  task automatic test_abort(input logic ks, input int pre_ticks, input string nm);
    logic [22:0] e;
    int n_done = 0;
    start = 1; key_same = ks;
    tick();
    start = 0;
    for (int i = 0; i < pre_ticks; i++) tick();
    if (ks) begin
      n_checks++;
      if (rnd_no !== 4'd5) begin n_fail++; $display("FAIL %s_pre rnd got %0d want 5", nm, rnd_no); end
    end
    abort = 1;
    tick();
    abort = 0;
    e = exp_vec(S_IDLE, 0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL %s_idle got %h want %h", nm, obs, e); end
    for (int i = 0; i < 25; i++) begin
      if (done) n_done++;
      tick();
    end
    n_checks++;
    if (n_done !== 0) begin n_fail++; $display("FAIL %s_no_done got %0d want 0", nm, n_done); end
  endtask

  task automatic test_rst_mid_round();
    logic [22:0] e;
    start = 1; key_same = 1;
    tick();
    start = 0;
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (rnd_no !== 4'd3) begin n_fail++; $display("FAIL rst_mid_pre rnd got %0d want 3", rnd_no); end
    rst = 1; start = 1;
    tick();
    e = exp_vec(S_IDLE, 0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rst_mid_idle got %h want %h", obs, e); end
    rst = 0; start = 0;
    tick();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rst_mid_no_resume got %h want %h", obs, e); end
    start = 1;
    tick();
    start = 0;
    e = exp_vec(S_ROUND, 10);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rst_mid_restart got %h want %h", obs, e); end
    abort = 1;
    tick();
    abort = 0;
  endtask

  initial begin
    rst = 1; start = 0; key_same = 0; abort = 0;
    test_reset();
    test_full_kexp();
    test_key_same();
    test_back_to_back();
    test_abort(1'b1, 5, "abort_round");
    test_abort(1'b0, 6, "abort_kexp");
    test_rst_mid_round();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_dec_cntx.md
AES_DEC_CNTX -- requirements
Module: aes_dec_cntx

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  reset, synchronous and active-high.
REQ-003: start  input  1  request one decryption; sampled only while accept=1.
REQ-004: key_same  input  1  sampled with start; 1 = key schedule already holds round-10 key, so skip forward expansion.
REQ-005: abort  input  1  synchronous cancel of the current operation.
REQ-006: accept  output  1  controller is idle and can take start.
REQ-007: busy  output  1  an operation is in progress (KEXP or ROUND).
REQ-008: rnd_no  output  4  current inverse round, 10 down to 0; 0 outside ROUND.
REQ-009: enb_isb  output  1  InvSubBytes enable.
REQ-010: enb_isr  output  1  InvShiftRows enable.
REQ-011: enb_imc  output  1  InvMixColumns enable.
REQ-012: enb_ar  output  1  AddRoundKey enable.
REQ-013: enb_ks  output  1  key-schedule step enable.
REQ-014: ks_dir  output  1  key-schedule direction: 0 = forward (key r to r+1), 1 = inverse (key r to r-1).
REQ-015: done  output  1  one-cycle pulse marking a completed decryption.
REQ-016: completed_round  output  10  one-hot progress indicator for test benches.

Function
REQ-017: States SHALL be IDLE, KEXP, ROUND and DONE; all outputs SHALL be decoded from registered state and counters, with no combinational path from any input to any output.
REQ-018: accept SHALL be 1 only in IDLE; busy SHALL be 1 only in KEXP and ROUND; done SHALL be 1 only in DONE.
REQ-019: Handshake: start=1 while in IDLE SHALL be accepted at that edge; start in any other state SHALL be ignored.
REQ-020: On acceptance, key_same=0 SHALL select KEXP with key counter kcnt=1, and key_same=1 SHALL select ROUND directly with rnd_no=10.
REQ-021: KEXP SHALL last exactly 10 cycles (kcnt 1..10), with enb_ks=1 and ks_dir=0; all datapath enables and rnd_no SHALL be 0.
REQ-022: Leaving KEXP: when kcnt=10, the next state SHALL be ROUND with rnd_no=10.
REQ-023: ROUND SHALL last exactly 11 cycles, with rnd_no decrementing by 1 per cycle from 10 to 0; the decrement SHALL never wrap below 0.
REQ-024: Enables at rnd_no=10 (initial round): enb_ar=1 and enb_isb=enb_isr=enb_imc=0.
REQ-025: Enables at rnd_no=9..1: enb_isr, enb_isb, enb_ar and enb_imc SHALL all be 1.
REQ-026: Enables at rnd_no=0 (final round): enb_isr, enb_isb and enb_ar SHALL be 1, and enb_imc=0.
REQ-027: In ROUND, enb_ks SHALL be 1 with ks_dir=1 for rnd_no=10..1, and enb_ks SHALL be 0 at rnd_no=0.
REQ-028: completed_round SHALL have bit (10-rnd_no) set for rnd_no=10..1 in ROUND, and SHALL be all-zero otherwise (including at rnd_no=0).
REQ-029: After rnd_no=0, the state SHALL go to DONE for exactly 1 cycle, then return to IDLE.
REQ-030: Latency from the start-accept edge to done high SHALL be 22 cycles with key_same=0, and 12 cycles with key_same=1.
REQ-031: abort=1 in KEXP, ROUND or DONE SHALL return the controller to IDLE at the next edge; no done pulse, and all counters cleared.
REQ-032: abort=1 in IDLE SHALL have no effect, and abort SHALL take priority over start.
REQ-033: ks_dir SHALL be 0 in IDLE and DONE, and all enables SHALL be 0 in IDLE and DONE.

Reset
REQ-034: rst=1 at a clock edge SHALL force IDLE with kcnt=0 and rnd_no=0, overriding start and abort, in any state including mid-KEXP or mid-ROUND.
REQ-035: After a reset edge, accept=1, and busy, done, every enable, ks_dir and completed_round SHALL be 0.
REQ-036: A start held high during rst SHALL be ignored; the first acceptance SHALL occur at the first edge with rst=0.

Verification
REQ-037: Reset, then start=1 with key_same=0 for 1 cycle -> 10 cycles with enb_ks=1 and ks_dir=0; then rnd_no 10,9,...,0; done=1 on the 22nd cycle after acceptance; accept returns to 1 on the next cycle.
REQ-038: Start with key_same=1 -> first busy cycle has rnd_no=10, enb_ar=1 and enb_imc=0; done on the 12th cycle after acceptance.
REQ-039: Per-round enable check over a full run -> enb_imc=1 exactly 9 times; enb_ar=1 exactly 11 times; enb_ks=1 with ks_dir=1 exactly 10 times; completed_round walks 0x001 through 0x200.
REQ-040: start held high continuously -> back-to-back operations with exactly one IDLE cycle between each done and the next acceptance; no start taken while busy.
REQ-041: abort=1 at rnd_no=5 -> next cycle IDLE with rnd_no=0 and accept=1, and no done pulse; abort during KEXP at kcnt=7 gives the same result.
REQ-042: rst=1 mid-ROUND at rnd_no=3 while start=1 -> next cycle shows all REQ-035 values; operation resumes only after rst=0 and a fresh start.
